// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
// - pc_op_t    : the single operation executed in a cycle
// - pc_state_t : RUN / HALT state of the counter
// - pc_sel_op  : fixed-priority request arbiter (ret > call > inc > write > ins_con)
package pc_pkg;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_INS_CON = 3'd1,
        OP_WRITE   = 3'd2,
        OP_INC     = 3'd3,
        OP_CALL    = 3'd4,
        OP_RET     = 3'd5
    } pc_op_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_t;

    // Lower-priority requests in the same cycle are dropped, never queued.
    function automatic pc_op_t pc_sel_op(
        input logic ret,
        input logic call,
        input logic inc,
        input logic write,
        input logic ins_con
    );
        pc_op_t op;
        if (ret) begin
            op = OP_RET;
        end else if (call) begin
            op = OP_CALL;
        end else if (inc) begin
            op = OP_INC;
        end else if (write) begin
            op = OP_WRITE;
        end else if (ins_con) begin
            op = OP_INS_CON;
        end else begin
            op = OP_NONE;
        end
        return op;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address stack (LIFO).
// Ports:
//   clk, rst      - clock, synchronous active-high reset (clears pointer only)
//   push, din     - push din when not full (ignored when full)
//   pop           - drop top entry when not empty (ignored when empty)
//   dout          - combinational top-of-stack (zero when empty)
//   full, empty   - registered occupancy flags, valid the cycle after a change
module ret_stack #(
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] DEPTH_C = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] mem_r [STACK_DEPTH];
    logic [SP_W-1:0]   sp_r;
    logic [SP_W-1:0]   sp_next_s;
    logic [SP_W-1:0]   top_s;
    logic              full_r;
    logic              empty_r;
    logic              do_pop_s;
    logic              do_push_s;

    // Qualify requests against occupancy; pop wins if both are presented.
    always_comb begin
        do_pop_s  = pop & ~empty_r;
        do_push_s = push & ~full_r & ~do_pop_s;
        top_s     = sp_r - SP_W'(1);
        if (do_pop_s) begin
            sp_next_s = top_s;
        end else if (do_push_s) begin
            sp_next_s = sp_r + SP_W'(1);
        end else begin
            sp_next_s = sp_r;
        end
    end

    // Top-of-stack read; an empty stack presents zero rather than stale data.
    always_comb begin
        if (empty_r) begin
            dout = '0;
        end else begin
            dout = mem_r[top_s[IDX_W-1:0]];
        end
    end

    // Storage write; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && do_push_s) begin
            mem_r[sp_r[IDX_W-1:0]] <= din;
        end
    end

    // Stack pointer and flags, flags computed from the next pointer value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_r    <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            sp_r    <= sp_next_s;
            full_r  <= (sp_next_s == DEPTH_C);
            empty_r <= (sp_next_s == SP_W'(0));
        end
    end

    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/pc_unit.sv
// Parametrised program counter with call/return stack and finish/halt.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_bus, write       - load out_bus from in_bus
//   inc                 - out_bus + 1 (wraps)
//   ins_con, tr_pc,
//   mbr_pc              - jump to {tr_pc, mbr_pc}
//   call                - push out_bus+1 and jump to {tr_pc, mbr_pc}
//   ret                 - pop return address into out_bus
//   out_bus             - registered program counter
//   finish_signal       - sticky, set one cycle after out_bus shows FINISH_ADDR
//   stack_full/empty    - registered stack occupancy flags
//   stack_err           - sticky, call on full or ret on empty
module pc_unit import pc_pkg::*; #(
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 4,
    parameter int FINISH_ADDR = 333,
    parameter int RESET_ADDR  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   in_bus,
    input  logic                write,
    input  logic                inc,
    input  logic                ins_con,
    input  logic [ADDR_W/2-1:0] tr_pc,
    input  logic [ADDR_W/2-1:0] mbr_pc,
    input  logic                call,
    input  logic                ret,
    output logic [ADDR_W-1:0]   out_bus,
    output logic                finish_signal,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                stack_err
);

    localparam logic [ADDR_W-1:0] FINISH_C = ADDR_W'(FINISH_ADDR);
    localparam logic [ADDR_W-1:0] RESET_C  = ADDR_W'(RESET_ADDR);

    pc_state_t         state_r;
    logic [ADDR_W-1:0] out_bus_r;
    logic              finish_r;
    logic              stack_err_r;

    pc_op_t            op_s;
    logic              run_s;
    logic              push_s;
    logic              pop_s;
    logic              err_set_s;
    logic [ADDR_W-1:0] jump_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] tos_s;
    logic              full_s;
    logic              empty_s;

    ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (pc_inc_s),
        .dout  (tos_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Operation select and qualification. The cycle in which FINISH_ADDR is
    // detected already counts as halted, so no stack side effects happen then.
    always_comb begin
        op_s      = pc_sel_op(ret, call, inc, write, ins_con);
        run_s     = (state_r == ST_RUN) && (out_bus_r != FINISH_C) && !rst;
        jump_s    = {tr_pc, mbr_pc};
        pc_inc_s  = out_bus_r + ADDR_W'(1);
        push_s    = run_s && (op_s == OP_CALL) && !full_s;
        pop_s     = run_s && (op_s == OP_RET) && !empty_s;
        err_set_s = ((op_s == OP_CALL) && full_s) || ((op_s == OP_RET) && empty_s);
    end

    // Next program counter for a running cycle.
    always_comb begin
        pc_next_s = out_bus_r;
        case (op_s)
            OP_RET: begin
                if (!empty_s) begin
                    pc_next_s = tos_s;
                end else begin
                    pc_next_s = out_bus_r;
                end
            end
            OP_CALL: begin
                if (!full_s) begin
                    pc_next_s = jump_s;
                end else begin
                    pc_next_s = out_bus_r;
                end
            end
            OP_INC:     pc_next_s = pc_inc_s;
            OP_WRITE:   pc_next_s = in_bus;
            OP_INS_CON: pc_next_s = jump_s;
            default:    pc_next_s = out_bus_r;
        endcase
    end

    // RUN/HALT state machine with registered PC, finish and error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            out_bus_r   <= RESET_C;
            finish_r    <= 1'b0;
            stack_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (out_bus_r == FINISH_C) begin
                        state_r  <= ST_HALT;
                        finish_r <= 1'b1;
                    end else begin
                        out_bus_r <= pc_next_s;
                        if (err_set_s) begin
                            stack_err_r <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    finish_r <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: fail safe by freezing the counter.
                    state_r  <= ST_HALT;
                    finish_r <= 1'b1;
                end
            endcase
        end
    end

    assign out_bus       = out_bus_r;
    assign finish_signal = finish_r;
    assign stack_full    = full_s;
    assign stack_empty   = empty_s;
    assign stack_err     = stack_err_r;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic [15:0] in_bus;
    logic        write;
    logic        inc;
    logic        ins_con;
    logic [7:0]  tr_pc;
    logic [7:0]  mbr_pc;
    logic        call;
    logic        ret;
    logic [15:0] out_bus;
    logic        finish_signal;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: PC value, return addresses as a queue, sticky bits.
    logic [15:0] m_pc;
    logic        m_fin;
    logic        m_err;
    logic [15:0] m_stk [$];

    pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .in_bus        (in_bus),
        .write         (write),
        .inc           (inc),
        .ins_con       (ins_con),
        .tr_pc         (tr_pc),
        .mbr_pc        (mbr_pc),
        .call          (call),
        .ret           (ret),
        .out_bus       (out_bus),
        .finish_signal (finish_signal),
        .stack_full    (stack_full),
        .stack_empty   (stack_empty),
        .stack_err     (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model at the edge, settle.
    task automatic step(input logic r, input logic rt, input logic cl, input logic ic,
                        input logic wr, input logic icn, input logic [15:0] inb,
                        input logic [7:0] tr, input logic [7:0] mb);
        rst = r; ret = rt; call = cl; inc = ic; write = wr; ins_con = icn;
        in_bus = inb; tr_pc = tr; mbr_pc = mb;
        @(posedge clk);
        if (r) begin
            m_pc = 16'd0; m_fin = 1'b0; m_err = 1'b0; m_stk.delete();
        end else if (m_fin) begin
            m_pc = m_pc;
        end else if (m_pc == 16'd333) begin
            m_fin = 1'b1;
        end else if (rt) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_err = 1'b1;
        end else if (cl) begin
            if (m_stk.size() < 4) begin
                m_stk.push_back(m_pc + 16'd1);
                m_pc = {tr, mb};
            end else m_err = 1'b1;
        end else if (ic) m_pc = m_pc + 16'd1;
        else if (wr) m_pc = inb;
        else if (icn) m_pc = {tr, mb};
        #1;
        rst = 1'b0; ret = 1'b0; call = 1'b0; inc = 1'b0; write = 1'b0; ins_con = 1'b0;
    endtask

    task automatic test_reset_inc_wrap();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        total_cnt++;
        if ({out_bus, finish_signal, stack_full, stack_empty, stack_err} !== {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_state: got pc=%h fin=%b full=%b empty=%b err=%b, want 0000 0 0 1 0",
                     out_bus, finish_signal, stack_full, stack_empty, stack_err);
        else pass_cnt++;
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
            total_cnt++;
            if (out_bus !== 16'(i)) $display("FAIL inc_%0d: got %h want %h", i, out_bus, 16'(i));
            else pass_cnt++;
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h00);
        total_cnt++;
        if (out_bus !== 16'hFFFF) $display("FAIL write_ffff: got %h want ffff", out_bus);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        total_cnt++;
        if ({out_bus, finish_signal} !== {16'h0000, 1'b0})
            $display("FAIL inc_wrap: got pc=%h fin=%b want 0000 0", out_bus, finish_signal);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0005, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 8'h12, 8'h34);
        total_cnt++;
        if (out_bus !== 16'h0006) $display("FAIL prio_inc: got %h want 0006", out_bus);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 8'h12, 8'h34);
        total_cnt++;
        if (out_bus !== 16'h0040) $display("FAIL prio_write: got %h want 0040", out_bus);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 8'h12, 8'h34);
        total_cnt++;
        if (out_bus !== 16'h1234) $display("FAIL prio_ins_con: got %h want 1234", out_bus);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0777, 8'h55, 8'h66);
        total_cnt++;
        if (out_bus !== 16'h1234) $display("FAIL idle_hold: got %h want 1234", out_bus);
        else pass_cnt++;
    endtask

    task automatic test_call_ret();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h01, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h02, 8'h00);
        total_cnt++;
        if ({out_bus, stack_empty} !== {16'h0200, 1'b0})
            $display("FAIL call_nest: got pc=%h empty=%b want 0200 0", out_bus, stack_empty);
        else pass_cnt++;
        step(1'b1 & 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h09, 8'h09);
        total_cnt++;
        if (out_bus !== 16'h0101) $display("FAIL ret_1: got %h want 0101", out_bus);
        else pass_cnt++;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        total_cnt++;
        if ({out_bus, stack_empty, stack_err} !== {16'h0011, 1'b1, 1'b0})
            $display("FAIL ret_2: got pc=%h empty=%b err=%b want 0011 1 0", out_bus, stack_empty, stack_err);
        else pass_cnt++;
    endtask

    task automatic test_overflow_underflow();
        logic [15:0] x;
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h03, 8'(i));
        total_cnt++;
        if ({stack_full, stack_err} !== {1'b1, 1'b0})
            $display("FAIL stack_fill: got full=%b err=%b want 1 0", stack_full, stack_err);
        else pass_cnt++;
        x = m_pc;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h0A, 8'h0B);
        total_cnt++;
        if ({out_bus, stack_err} !== {x, 1'b1})
            $display("FAIL overflow: got pc=%h err=%b want %h 1", out_bus, stack_err, x);
        else pass_cnt++;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        total_cnt++;
        if ({out_bus, stack_err} !== {16'h0000, 1'b1})
            $display("FAIL underflow: got pc=%h err=%b want 0000 1", out_bus, stack_err);
        else pass_cnt++;
    endtask

    task automatic test_finish();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd332, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        total_cnt++;
        if ({out_bus, finish_signal} !== {16'd333, 1'b0})
            $display("FAIL reach_finish: got pc=%0d fin=%b want 333 0", out_bus, finish_signal);
        else pass_cnt++;
        // Operation in the detection cycle must also be ignored.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        total_cnt++;
        if ({out_bus, finish_signal} !== {16'd333, 1'b1})
            $display("FAIL finish_set: got pc=%0d fin=%b want 333 1", out_bus, finish_signal);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0123, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h44, 8'h44);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        total_cnt++;
        if ({out_bus, finish_signal, stack_empty, stack_err} !== {16'd333, 1'b1, 1'b1, 1'b0})
            $display("FAIL halt_hold: got pc=%0d fin=%b empty=%b err=%b want 333 1 1 0",
                     out_bus, finish_signal, stack_empty, stack_err);
        else pass_cnt++;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        total_cnt++;
        if ({out_bus, finish_signal} !== {16'h0000, 1'b0})
            $display("FAIL finish_clear: got pc=%h fin=%b want 0000 0", out_bus, finish_signal);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_call();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h05, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h06, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h07, 8'h00);
        total_cnt++;
        if ({out_bus, stack_empty, stack_full} !== {16'h0000, 1'b1, 1'b0})
            $display("FAIL rst_mid_call: got pc=%h empty=%b full=%b want 0000 1 0",
                     out_bus, stack_empty, stack_full);
        else pass_cnt++;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        total_cnt++;
        if ({out_bus, stack_err} !== {16'h0000, 1'b1})
            $display("FAIL ret_after_rst: got pc=%h err=%b want 0000 1", out_bus, stack_err);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] inb;
        for (int n = 0; n < 800; n++) begin
            inb = ($urandom_range(0, 7) == 0) ? 16'(331 + $urandom_range(0, 2)) : 16'($urandom);
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 15, inb,
                 8'($urandom), ($urandom_range(0, 15) == 0) ? 8'd77 : 8'($urandom));
            total_cnt++;
            if ({out_bus, finish_signal, stack_full, stack_empty, stack_err} !==
                {m_pc, m_fin, (m_stk.size() == 4), (m_stk.size() == 0), m_err})
                $display("FAIL random_%0d: got pc=%h fin=%b full=%b empty=%b err=%b want %h %b %b %b %b",
                         n, out_bus, finish_signal, stack_full, stack_empty, stack_err,
                         m_pc, m_fin, (m_stk.size() == 4), (m_stk.size() == 0), m_err);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b0; ret = 1'b0; call = 1'b0; inc = 1'b0; write = 1'b0; ins_con = 1'b0;
        in_bus = 16'h0000; tr_pc = 8'h00; mbr_pc = 8'h00;
        m_pc = 16'h0000; m_fin = 1'b0; m_err = 1'b0;
        @(negedge clk);
        test_reset_inc_wrap();
        test_priority();
        test_call_ret();
        test_overflow_underflow();
        test_finish();
        test_reset_mid_call();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the downsampling processor; successor to the single-width, fixed-finish counter.
- Holds the instruction address and drives it onto `out_bus` for fetch.
- Supports increment, bus load, and byte-split jump from TR/MBR.
- New in this generation:
  - call/return through a hardware return-address stack (LIFO);
  - a programmable finish address that halts the counter;
  - overflow/underflow error reporting.

Parameters:
- `ADDR_W`, 16, address width; must be even (jump target = {`tr_pc`, `mbr_pc`}, `ADDR_W`/2 bits each).
- `STACK_DEPTH`, 4, return-address stack entries (≥1).
- `FINISH_ADDR`, 333, address whose appearance on `out_bus` raises `finish_signal` and halts.
- `RESET_ADDR`, 0, value loaded into `out_bus` on reset.

Ports:
- `clk`  input  1  system clock, all logic on posedge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_bus`  input  `ADDR_W`  load value for `write`.
- `write`  input  1  load `out_bus` <= `in_bus`.
- `inc`  input  1  `out_bus` <= `out_bus` + 1 (PC1).
- `ins_con`  input  1  jump `out_bus` <= {`tr_pc`, `mbr_pc`}.
- `tr_pc`  input  `ADDR_W`/2  jump target high half.
- `mbr_pc`  input  `ADDR_W`/2  jump target low half.
- `call`  input  1  push `out_bus`+1, jump to {`tr_pc`, `mbr_pc`}.
- `ret`  input  1  pop top of stack into `out_bus`.
- `out_bus`  output  `ADDR_W`  current program counter (registered).
- `finish_signal`  output  1  sticky: program reached `FINISH_ADDR`.
- `stack_full`  output  1  stack holds `STACK_DEPTH` entries.
- `stack_empty`  output  1  stack holds 0 entries.
- `stack_err`  output  1  sticky: call on full or ret on empty.

Behaviour:
- **Reset (`rst`=1 at posedge)** wins over everything:
  - `out_bus`=`RESET_ADDR`, `finish_signal`=0, `stack_err`=0;
  - stack pointer=0, so `stack_empty`=1 and `stack_full`=0.
  - Stack contents need not be cleared.
  - Reset mid-operation discards any pending call/ret in that cycle.
- **Single operation per cycle**, fixed priority: `ret` > `call` > `inc` > `write` > `ins_con`. Lower-priority requests in the same cycle are ignored, not queued. No request: `out_bus` holds.
- **Latency:** every operation updates `out_bus` at the posedge it is sampled (1 cycle).
- **inc:** modulo 2^`ADDR_W`; all-ones wraps to 0.
- **write:** `out_bus` <= `in_bus`.
- **ins_con:** `out_bus` <= {`tr_pc`, `mbr_pc`}.
- **call:**
  - Not full: `stack[sp]` <= `out_bus`+1 (mod 2^`ADDR_W`), `sp`++, `out_bus` <= {`tr_pc`, `mbr_pc`}.
  - Full: no push, no jump, `out_bus` holds, `stack_err` <= 1.
- **ret:**
  - Not empty: `out_bus` <= `stack[sp-1]`, `sp`--.
  - Empty: `out_bus` holds, `stack_err` <= 1.
- `ret` and `call` in the same cycle: only `ret` executes.
- **Flags:** `stack_full`/`stack_empty` are registered, derived from `sp`, and valid the cycle after the change.
- **Finish:**
  - At any posedge where the registered `out_bus` == `FINISH_ADDR`, `finish_signal` <= 1 (one cycle after the address appears).
  - From that posedge on, the unit is HALTED: all operations are ignored and `out_bus` freezes.
  - Only `rst` clears it.
  - An operation sampled in the same cycle as the finish detection is also ignored.
- **State:** RUN → (`out_bus`==`FINISH_ADDR`) → HALT → (`rst`) → RUN. HALT is equivalent to `finish_signal`=1.

Decomposition:
- Shared package `pc_pkg`:
  - enum `pc_op_t` {OP_NONE, OP_INS_CON, OP_WRITE, OP_INC, OP_CALL, OP_RET};
  - function `pc_sel_op(ret, call, inc, write, ins_con)` implementing the priority.
- One sub-module: `ret_stack`:
  - parameters `ADDR_W`, `STACK_DEPTH`;
  - ports `push`, `pop`, `din`, `dout` (combinational top-of-stack), `full`, `empty`.
  - It ignores push when full and pop when empty.
  - `pc_unit` owns the error/halt logic.

Test Plan:
1. **Reset/increment/wrap:** `rst` 1 cycle, then `inc`×3 → `out_bus` 0, 1, 2, 3. Then `write` `in_bus`=0xFFFF, `inc` → `out_bus`=0x0000, `finish_signal`=0.
2. **Priority:** same cycle `inc`=1, `write`=1 (`in_bus`=0x0040), `ins_con`=1 (`tr_pc`=0x12, `mbr_pc`=0x34) from `out_bus`=5 → `out_bus`=6. Next cycle `write`+`ins_con` → 0x0040. Next cycle `ins_con` alone → 0x1234.
3. **Call/return nesting:**
   - At `out_bus`=0x0010: `call` to 0x0100, then `call` to 0x0200 → `out_bus`=0x0200, `stack_empty`=0.
   - Then `ret` → 0x0101; `ret` → 0x0011; `stack_empty`=1, `stack_err`=0.
4. **Overflow/underflow:**
   - 4 calls fill stack (`stack_full`=1). 5th call from `out_bus`=X → `out_bus` stays X, `stack_err`=1.
   - After `rst`, `ret` on empty → `out_bus` stays 0, `stack_err`=1.
5. **Finish/halt:**
   - `write` `in_bus`=332, `inc` → `out_bus`=333; next posedge `finish_signal`=1.
   - Subsequent `inc`/`write`/`call` → `out_bus` stays 333.
   - `rst` → `out_bus`=0, `finish_signal`=0.
6. **Reset mid-call:** `rst` and `call` asserted together with 2 entries stacked → `out_bus`=0, `stack_empty`=1, no push; following `ret` sets `stack_err`=1.
